// File: rtl/uart_rx_port_if.sv
// CPU-side I/O port bundle for the UART receive front-end.
// The slave side is the port itself; the master side is the bus/CPU.
interface uart_rx_port_if;
  logic       rx;
  logic       cs;
  logic       addr;
  logic       iorc_n;
  logic       iowc_n;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  modport slave (
    input  rx, cs, addr, iorc_n, iowc_n, wdata,
    output rdata, irq
  );

  modport master (
    output rx, cs, addr, iorc_n, iowc_n, wdata,
    input  rdata, irq
  );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a 16x oversampled deframer and a small receive FIFO.
// The FIFO is exposed as an I/O-mapped DATA/STAT port and raises a level IRQ.
module uart_rx_port #(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 9600,
  parameter int FIFO_AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_port_if.slave bus
);
  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIVW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               rxMeta_q, rxSync_q, rxPrev_q;
  state_t             state_q;
  logic [DIVW-1:0]    tickCnt_q;
  logic [3:0]         ovsCnt_q;
  logic [2:0]         bitIdx_q;
  logic [7:0]         shift_q;
  logic               pushReq_q, frameReq_q;
  logic [7:0]         pushData_q;

  logic [7:0]         fifoMem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
  logic [FIFO_AW:0]   count_q;
  logic               overrun_q, frameErr_q, irqEn_q;
  logic               iorcPrev_q, iowcPrev_q, readArm_q, writeArm_q;
  logic [1:0]         wrCtrl_q;
  logic [7:0]         rdata_q;
  logic               irq_q;

  logic       tick, rxFall, nonEmpty, full;
  logic       iorcRise, iowcRise, doPop, doWrite, doPush;
  logic [7:0] statByte, headByte;

  assign tick     = (state_q != IDLE) && (tickCnt_q == DIVW'(DIV - 1));
  assign rxFall   = rxPrev_q & ~rxSync_q;
  assign nonEmpty = (count_q != '0);
  assign full     = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign iorcRise = ~iorcPrev_q & bus.iorc_n;
  assign iowcRise = ~iowcPrev_q & bus.iowc_n;
  assign doPop    = iorcRise & readArm_q & nonEmpty;
  assign doWrite  = iowcRise & writeArm_q;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign doPush   = pushReq_q & (~full | doPop);
  assign statByte = {3'b000, irqEn_q, frameErr_q, overrun_q, full, nonEmpty};
  assign headByte = nonEmpty ? fifoMem_q[rdPtr_q] : 8'h00;

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= bus.rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      ovsCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      pushReq_q  <= 1'b0;
      frameReq_q <= 1'b0;
      pushData_q <= '0;
    end else begin
      pushReq_q  <= 1'b0;
      frameReq_q <= 1'b0;
      if (state_q == IDLE) begin
        tickCnt_q <= '0;
        ovsCnt_q  <= '0;
        if (rxFall) state_q <= START;
      end else begin
        tickCnt_q <= tick ? '0 : tickCnt_q + DIVW'(1);
        if (tick) ovsCnt_q <= ovsCnt_q + 4'd1;
        unique case (state_q)
          START: if (tick && ovsCnt_q == 4'd7) begin
            ovsCnt_q <= '0;
            bitIdx_q <= '0;
            state_q  <= rxSync_q ? IDLE : DATA;
          end
          DATA: if (tick && ovsCnt_q == 4'd15) begin
            shift_q[bitIdx_q] <= rxSync_q;
            bitIdx_q          <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) state_q <= STOP;
          end
          STOP: if (tick && ovsCnt_q == 4'd15) begin
            pushReq_q  <= rxSync_q;
            frameReq_q <= ~rxSync_q;
            pushData_q <= shift_q;
            state_q    <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) fifoMem_q[wrPtr_q] <= pushData_q;
  end

  // Bus strobes are qualified while low and acted on at their rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      irqEn_q    <= 1'b0;
      iorcPrev_q <= 1'b1;
      iowcPrev_q <= 1'b1;
      readArm_q  <= 1'b0;
      writeArm_q <= 1'b0;
      wrCtrl_q   <= '0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      iorcPrev_q <= bus.iorc_n;
      iowcPrev_q <= bus.iowc_n;

      if (!bus.iorc_n && bus.cs && !bus.addr) readArm_q <= 1'b1;
      else if (iorcRise)                      readArm_q <= 1'b0;

      if (!bus.iowc_n && bus.cs && bus.addr) begin
        writeArm_q <= 1'b1;
        wrCtrl_q   <= bus.wdata[1:0];
      end else if (iowcRise) begin
        writeArm_q <= 1'b0;
      end

      if (doPush) wrPtr_q <= wrPtr_q + FIFO_AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + FIFO_AW'(1);
      if (doPush && !doPop)      count_q <= count_q + (FIFO_AW + 1)'(1);
      else if (doPop && !doPush) count_q <= count_q - (FIFO_AW + 1)'(1);

      if (doWrite) begin
        irqEn_q <= wrCtrl_q[0];
        if (wrCtrl_q[1]) begin
          overrun_q  <= 1'b0;
          frameErr_q <= 1'b0;
        end
      end
      if (pushReq_q && !doPush) overrun_q  <= 1'b1;
      if (frameReq_q)           frameErr_q <= 1'b1;

      rdata_q <= bus.addr ? statByte : headByte;
      irq_q   <= irqEn_q & nonEmpty;
    end
  end
endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port: frames are driven bit by bit on rx and
// expected bytes go through a scoreboard queue that DATA reads pop and compare.
`timescale 1ns/1ps
module tb_uart_rx_port;
  localparam int CLK_HZ  = 50000000;
  localparam int BAUD    = 1562500;
  localparam int BIT_CLK = 32;

  logic clk = 1'b0;
  logic rst_n;
  uart_rx_port_if bus ();

  uart_rx_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_AW(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  int passCount  = 0;
  int failCount  = 0;
  int checkCount = 0;

  logic [7:0] expQ [$];
  logic       mOverrun = 1'b0;
  logic       mFrameErr = 1'b0;
  logic       mIrqEn = 1'b0;

  function automatic logic [7:0] expStat();
    return {3'b000, mIrqEn, mFrameErr, mOverrun, (expQ.size() == 16), (expQ.size() != 0)};
  endfunction

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  // mode 0: plain frame, 1: probe irq around the push, 2: overlap a DATA pop with the push
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int mode);
    logic [9:0] frame;
    logic [7:0] exp;
    frame = {stopBit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = frame[i];
      if (i == 9 && mode == 1) begin
        waitClk(20);
        checkOutput("irqBeforeRise", {7'b0, bus.irq}, 8'h00);
        waitClk(1);
        checkOutput("irqRise", {7'b0, bus.irq}, 8'h01);
        waitClk(BIT_CLK - 21);
      end else if (i == 9 && mode == 2) begin
        bus.cs = 1'b1; bus.addr = 1'b0; bus.iorc_n = 1'b0;
        waitClk(3);
        exp = expQ.pop_front();
        checkOutput("concurrentHead", bus.rdata, exp);
        waitClk(16);
        bus.iorc_n = 1'b1;
        waitClk(2);
        bus.cs = 1'b0;
        waitClk(BIT_CLK - 21);
      end else begin
        waitClk(BIT_CLK);
      end
    end
    bus.rx = 1'b1;
    if (stopBit) begin
      if (expQ.size() < 16) expQ.push_back(data);
      else mOverrun = 1'b1;
    end else begin
      mFrameErr = 1'b1;
    end
    waitClk(4);
  endtask

  task automatic readReg(input logic a, output logic [7:0] val);
    bus.cs = 1'b1; bus.addr = a; bus.iorc_n = 1'b0;
    waitClk(2);
    val = bus.rdata;
    bus.iorc_n = 1'b1;
    waitClk(2);
    bus.cs = 1'b0;
    waitClk(1);
  endtask

  task automatic writeReg(input logic a, input logic [7:0] data);
    bus.cs = 1'b1; bus.addr = a; bus.wdata = data; bus.iowc_n = 1'b0;
    waitClk(2);
    bus.iowc_n = 1'b1;
    waitClk(2);
    bus.cs = 1'b0;
    waitClk(1);
    if (a) begin
      mIrqEn = data[0];
      if (data[1]) begin
        mOverrun  = 1'b0;
        mFrameErr = 1'b0;
      end
    end
  endtask

  task automatic checkStat(input string tag);
    logic [7:0] v;
    readReg(1'b1, v);
    checkOutput(tag, v, expStat());
  endtask

  task automatic checkData(input string tag);
    logic [7:0] v, exp;
    readReg(1'b0, v);
    exp = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
    checkOutput(tag, v, exp);
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0;
    bus.rx = 1'b1; bus.cs = 1'b0; bus.addr = 1'b0;
    bus.iorc_n = 1'b1; bus.iowc_n = 1'b1; bus.wdata = 8'h00;
    waitClk(3);
    checkOutput("resetRdata", bus.rdata, 8'h00);
    checkOutput("resetIrq", {7'b0, bus.irq}, 8'h00);
    rst_n = 1'b1;
    waitClk(3);
    checkOutput("idleRdata", bus.rdata, 8'h00);
    checkStat("idleStat");

    applyStimulus(8'hA5, 1'b1, 0);
    checkStat("singleStat");
    checkData("singleData");
    checkStat("singleStatEmpty");
    checkData("emptyRead");
    writeReg(1'b0, 8'h03);
    checkStat("addr0WriteIgnored");

    writeReg(1'b1, 8'h01);
    applyStimulus(8'h3C, 1'b1, 1);
    bus.cs = 1'b1; bus.addr = 1'b0; bus.iorc_n = 1'b0;
    waitClk(2);
    checkOutput("irqData", bus.rdata, expQ.pop_front());
    checkOutput("irqHeld", {7'b0, bus.irq}, 8'h01);
    bus.iorc_n = 1'b1;
    waitClk(2);
    checkOutput("irqFall", {7'b0, bus.irq}, 8'h00);
    bus.cs = 1'b0;
    waitClk(1);
    writeReg(1'b1, 8'h00);

    for (int b = 0; b < 17; b++) applyStimulus(8'(b), 1'b1, 0);
    checkStat("fullOverrunStat");
    for (int b = 0; b < 16; b++) checkData($sformatf("drain%0d", b));
    checkStat("drainedStat");
    writeReg(1'b1, 8'h02);
    checkStat("clearedStat");

    applyStimulus(8'h55, 1'b0, 0);
    checkStat("frameErrStat");
    bus.rx = 1'b0;
    waitClk(8);
    bus.rx = 1'b1;
    waitClk(4 * BIT_CLK);
    checkStat("glitchStat");
    writeReg(1'b1, 8'h02);

    applyStimulus(8'h11, 1'b1, 0);
    applyStimulus(8'h22, 1'b1, 2);
    checkStat("concurrentStat");
    checkData("concurrentNext");
    checkStat("concurrentEmpty");

    writeReg(1'b1, 8'h01);
    applyStimulus(8'h5A, 1'b1, 0);
    checkOutput("preResetIrq", {7'b0, bus.irq}, 8'h01);
    bus.rx = 1'b0;
    waitClk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      bus.rx = i[0];
      waitClk(BIT_CLK);
    end
    bus.rx = 1'b0;
    waitClk(BIT_CLK / 2);
    rst_n = 1'b0;
    bus.rx = 1'b1;
    waitClk(3);
    rst_n = 1'b1;
    expQ.delete();
    mOverrun = 1'b0; mFrameErr = 1'b0; mIrqEn = 1'b0;
    waitClk(2 * BIT_CLK);
    checkOutput("postResetIrq", {7'b0, bus.irq}, 8'h00);
    checkStat("postResetStat");
    applyStimulus(8'h81, 1'b1, 0);
    checkStat("afterResetStat");
    checkData("afterResetData");

    readReg(1'b1, v);
    checkOutput("finalStat", v, expStat());
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
